gpr_seq_ctrl: RTL and testbench

- Sequences one register-to-register operation at a time through the 8x8 general-purpose register file: read two source registers, start the ALU, capture its result, write back.
- Also shares the file's single write port between that writeback and an external load requester, using a 2-way round-robin arbiter.
- Sits between instruction decode (op side), the load/IO unit (ld side), the GPR file and the ALU.

---
 rtl/gpr_ctrl_pkg.sv | 35 +++
 rtl/gpr_wr_arbiter.sv | 40 ++++
 rtl/gpr_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_gpr_seq_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_ctrl_pkg.sv
// Purpose : shared constants and types for the GPR operation sequencer.
//           Default widths, FSM state codes and write-port grant encoding.
package gpr_ctrl_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 3;
    localparam int unsigned DEF_ALU_TIMEOUT = 15;

    // Sequencer FSM state codes
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_READ = 2'd1;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd2;
    localparam logic [ST_W-1:0] ST_WB   = 2'd3;

    // Owner of the GPR write port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SEQ  = 2'd1,
        GNT_LD   = 2'd2
    } gnt_e;

    // Collapse the one-hot arbiter grants into the encoded owner
    function automatic gnt_e gnt_encode(input logic gnt_seq, input logic gnt_ld);
        gnt_e sel;
        sel = GNT_NONE;
        if (gnt_seq) begin
            sel = GNT_SEQ;
        end else if (gnt_ld) begin
            sel = GNT_LD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/gpr_wr_arbiter.sv
// Purpose : 2-way round-robin arbiter for the GPR write port.
//           Grants are combinational; a registered pointer remembers who
//           should win the next tie (the requester not granted last time).
// Ports   : clk, reset (async active-low)
//           req_seq / req_ld  - write requests from sequencer / load unit
//           gnt_seq / gnt_ld  - grants, at most one high per cycle
module gpr_wr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req_seq,
    input  logic req_ld,
    output logic gnt_seq,
    output logic gnt_ld
);

    // 1 = load wins the next tie; cleared at reset so the sequencer goes first
    logic prio_ld_q;
    logic prio_ld_d;

    // Grant decode and pointer update on every grant
    always_comb begin
        gnt_seq   = req_seq & (~req_ld | ~prio_ld_q);
        gnt_ld    = req_ld & (~req_seq | prio_ld_q);
        prio_ld_d = prio_ld_q;
        if (gnt_seq) begin
            prio_ld_d = 1'b1;
        end else if (gnt_ld) begin
            prio_ld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_ld_q <= 1'b0;
        end else begin
            prio_ld_q <= prio_ld_d;
        end
    end

endmodule

// File: rtl/gpr_seq_ctrl.sv
// Purpose : sequences one register-to-register operation at a time
//           (READ -> EXEC -> optional WB) and shares the GPR write port
//           with an external load requester through a round-robin arbiter.
// Ports   : clk, reset (async active-low)
//           op_*        - operation request from decode (valid/ready)
//           ld_*        - load write request; ld_ready is the same-cycle grant
//           gpr_in*_add - GPR read addresses; gpr_out_* combinational read data
//           gpr_dest_add/gpr_data/gpr_we - GPR write port
//           alu_start/alu_a/alu_b/alu_done/alu_result - ALU handshake
//           done/err    - completion / timeout pulses; busy = not idle
module gpr_seq_ctrl
    import gpr_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned ALU_TIMEOUT = DEF_ALU_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic              op_wb,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] gpr_in1_add,
    output logic [ADDR_W-1:0] gpr_in2_add,
    input  logic [DATA_W-1:0] gpr_out_1,
    input  logic [DATA_W-1:0] gpr_out_2,
    output logic [ADDR_W-1:0] gpr_dest_add,
    output logic [DATA_W-1:0] gpr_data,
    output logic              gpr_we,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    logic [ST_W-1:0]   state_q,     state_d;
    logic [ADDR_W-1:0] in1_add_q,   in1_add_d;
    logic [ADDR_W-1:0] in2_add_q,   in2_add_d;
    logic [ADDR_W-1:0] rd_q,        rd_d;
    logic              wb_q,        wb_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              alu_start_q, alu_start_d;
    logic              done_c;
    logic              err_c;
    logic              req_seq;
    logic              req_ld;
    logic              gnt_seq;
    logic              gnt_ld;
    gnt_e              gnt_sel;

    // Load requests are masked while reset is held so nothing is written
    assign req_seq = (state_q == ST_WB);
    assign req_ld  = ld_valid & reset;

    gpr_wr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_seq (req_seq),
        .req_ld  (req_ld),
        .gnt_seq (gnt_seq),
        .gnt_ld  (gnt_ld)
    );

    // Sequencer next-state and pulse decode
    always_comb begin
        state_d     = state_q;
        in1_add_d   = in1_add_q;
        in2_add_d   = in2_add_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        alu_start_d = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Read addresses are loaded at accept so they are valid
                // throughout READ and then simply hold
                if (op_valid) begin
                    in1_add_d = op_rs1;
                    in2_add_d = op_rs2;
                    rd_d      = op_rd;
                    wb_d      = op_wb;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d     = gpr_out_1;
                alu_b_d     = gpr_out_2;
                cnt_d       = '0;
                alu_start_d = 1'b1;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_done) begin
                    result_d = alu_result;
                    if (wb_q) begin
                        state_d = ST_WB;
                    end else begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Last permitted EXEC cycle passed without a result
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                if (gnt_seq) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-port mux; idle port drives zeros
    always_comb begin
        gnt_sel      = gnt_encode(gnt_seq, gnt_ld);
        gpr_we       = 1'b0;
        gpr_dest_add = '0;
        gpr_data     = '0;
        case (gnt_sel)
            GNT_SEQ: begin
                gpr_we       = 1'b1;
                gpr_dest_add = rd_q;
                gpr_data     = result_q;
            end
            GNT_LD: begin
                gpr_we       = 1'b1;
                gpr_dest_add = ld_rd;
                gpr_data     = ld_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in1_add_q   <= '0;
            in2_add_q   <= '0;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in1_add_q   <= in1_add_d;
            in2_add_q   <= in2_add_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            alu_start_q <= alu_start_d;
        end
    end

    // op_ready is forced low while reset is held even though state is IDLE
    assign op_ready    = reset & (state_q == ST_IDLE);
    assign ld_ready    = gnt_ld;
    assign gpr_in1_add = in1_add_q;
    assign gpr_in2_add = in2_add_q;
    assign alu_start   = alu_start_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign done        = done_c;
    assign err         = err_c;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpr_seq_ctrl.sv
// Scoreboard bench for gpr_seq_ctrl: stimulus pushes expected write/done/err
// events tagged with their cycle; a negedge monitor pops and compares them.
module tb_gpr_seq_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              op_valid;
    logic              op_ready;
    logic [ADDR_W-1:0] op_rs1;
    logic [ADDR_W-1:0] op_rs2;
    logic [ADDR_W-1:0] op_rd;
    logic              op_wb;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] gpr_in1_add;
    logic [ADDR_W-1:0] gpr_in2_add;
    logic [DATA_W-1:0] gpr_out_1;
    logic [DATA_W-1:0] gpr_out_2;
    logic [ADDR_W-1:0] gpr_dest_add;
    logic [DATA_W-1:0] gpr_data;
    logic              gpr_we;
    logic              alu_start;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic              err;
    logic              busy;

    gpr_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_rs1       (op_rs1),
        .op_rs2       (op_rs2),
        .op_rd        (op_rd),
        .op_wb        (op_wb),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .gpr_in1_add  (gpr_in1_add),
        .gpr_in2_add  (gpr_in2_add),
        .gpr_out_1    (gpr_out_1),
        .gpr_out_2    (gpr_out_2),
        .gpr_dest_add (gpr_dest_add),
        .gpr_data     (gpr_data),
        .gpr_we       (gpr_we),
        .alu_start    (alu_start),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .done         (done),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment model (combinational read, write on edge)
    logic [DATA_W-1:0] regs [8];
    always @(posedge clk) begin
        if (gpr_we) regs[gpr_dest_add] <= gpr_data;
    end
    assign gpr_out_1 = regs[gpr_in1_add];
    assign gpr_out_2 = regs[gpr_in2_add];

    typedef struct {
        int                cyc;
        logic              we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic              done;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: every cycle with a write, done or err must match the next expectation
    always @(negedge clk) begin
        if (gpr_we || done || err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d we=%b dest=%0d data=0x%0h done=%b err=%b, required no event",
                         cyc, gpr_we, gpr_dest_add, gpr_data, done, err);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.we != gpr_we || mon_e.dest != gpr_dest_add ||
                    mon_e.data != gpr_data || mon_e.done != done || mon_e.err != err) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d we=%b dest=%0d data=0x%0h done=%b err=%b, required cyc=%0d we=%b dest=%0d data=0x%0h done=%b err=%b",
                             cyc, gpr_we, gpr_dest_add, gpr_data, done, err,
                             mon_e.cyc, mon_e.we, mon_e.dest, mon_e.data, mon_e.done, mon_e.err);
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic we, input logic [ADDR_W-1:0] dest,
                            input logic [DATA_W-1:0] data, input logic dn, input logic er);
        exp_t e;
        e.cyc  = c;
        e.we   = we;
        e.dest = dest;
        e.data = data;
        e.done = dn;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc=%0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({op_ready, ld_ready, gpr_we, alu_start, done, err, busy}), 32'd0);
        check({name, "_add"}, 32'({gpr_in1_add, gpr_in2_add, gpr_dest_add}), 32'd0);
        check({name, "_dat"}, 32'({alu_a, alu_b, gpr_data}), 32'd0);
    endtask

    // Present an op once the controller is idle; returns in the READ cycle
    task automatic issue_op(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                            input logic [ADDR_W-1:0] rd, input logic wb);
        int n = 0;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        check("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_rs1   = rs1;
        op_rs2   = rs2;
        op_rd    = rd;
        op_wb    = wb;
        tick();
        op_valid = 1'b0;
    endtask

    // Uncontended load write, granted in the cycle it is presented
    task automatic do_ld(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = data;
        push_exp(cyc, 1'b1, rd, data, 1'b0, 1'b0);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, required completion before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int n;
        reset      = 1'b0;
        op_valid   = 1'b0;
        op_rs1     = '0;
        op_rs2     = '0;
        op_rd      = '0;
        op_wb      = 1'b0;
        ld_valid   = 1'b1;   // must be ignored while reset is held
        ld_rd      = 3'd5;
        ld_data    = 8'hFF;
        alu_done   = 1'b0;
        alu_result = '0;

        // Reset state
        sample();
        check_all_zero("reset_state");
        tick();
        reset    = 1'b1;
        ld_valid = 1'b0;
        sample();
        check("op_ready_after_reset", 32'(op_ready), 32'd1);
        tick();

        // Preload R2=0x12, R3=0x34 through the load port
        do_ld(3'd2, 8'h12);
        do_ld(3'd3, 8'h34);

        // Basic op: R2+R3 -> R5, ALU answers in first EXEC cycle
        issue_op(3'd2, 3'd3, 3'd5, 1'b1);
        r = cyc;
        sample();
        check("read_add1", 32'(gpr_in1_add), 32'd2);
        check("read_add2", 32'(gpr_in2_add), 32'd3);
        check("busy_read", 32'(busy), 32'd1);
        tick();
        alu_done   = 1'b1;
        alu_result = 8'h46;
        push_exp(r + 2, 1'b1, 3'd5, 8'h46, 1'b1, 1'b0);
        sample();
        check("alu_start_exec0", 32'(alu_start), 32'd1);
        check("alu_a_basic", 32'(alu_a), 32'h12);
        check("alu_b_basic", 32'(alu_b), 32'h34);
        tick();
        alu_done = 1'b0;
        sample();
        check("alu_start_one_cycle", 32'(alu_start), 32'd0);
        tick();
        sample();
        check("op_ready_t4", 32'(op_ready), 32'd1);
        check("busy_t4", 32'(busy), 32'd0);
        tick();

        // Arbitration: fresh reset, seq wins first tie, ld next cycle
        apply_reset();
        issue_op(3'd2, 3'd3, 3'd6, 1'b1);
        r = cyc;
        tick();
        alu_done   = 1'b1;
        alu_result = 8'h5A;
        push_exp(r + 2, 1'b1, 3'd6, 8'h5A, 1'b1, 1'b0);
        tick();
        alu_done = 1'b0;
        ld_valid = 1'b1;
        ld_rd    = 3'd1;
        ld_data  = 8'hAA;
        push_exp(r + 3, 1'b1, 3'd1, 8'hAA, 1'b0, 1'b0);
        sample();
        check("ld_ready_lose", 32'(ld_ready), 32'd0);
        tick();
        sample();
        check("ld_ready_next", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;

        // Uncontended writeback so the sequencer holds the last grant
        issue_op(3'd2, 3'd3, 3'd7, 1'b1);
        r = cyc;
        tick();
        alu_done   = 1'b1;
        alu_result = 8'h11;
        push_exp(r + 2, 1'b1, 3'd7, 8'h11, 1'b1, 1'b0);
        tick();
        alu_done = 1'b0;
        tick();

        // Next tie: load wins, sequencer waits one cycle in WB
        issue_op(3'd1, 3'd2, 3'd4, 1'b1);
        r = cyc;
        tick();
        alu_done   = 1'b1;
        alu_result = 8'h22;
        sample();
        check("alu_a_from_load", 32'(alu_a), 32'hAA);
        check("alu_b_r2", 32'(alu_b), 32'h12);
        tick();
        alu_done = 1'b0;
        ld_valid = 1'b1;
        ld_rd    = 3'd0;
        ld_data  = 8'h3C;
        push_exp(r + 2, 1'b1, 3'd0, 8'h3C, 1'b0, 1'b0);
        push_exp(r + 3, 1'b1, 3'd4, 8'h22, 1'b1, 1'b0);
        sample();
        check("ld_ready_win", 32'(ld_ready), 32'd1);
        check("busy_wb_wait", 32'(busy), 32'd1);
        tick();
        ld_valid = 1'b0;
        sample();
        check("ld_ready_idle", 32'(ld_ready), 32'd0);
        tick();
        sample();
        check("busy_after_wb", 32'(busy), 32'd0);
        tick();

        // ALU timeout: err in the 15th EXEC cycle, no write
        issue_op(3'd2, 3'd3, 3'd5, 1'b1);
        r = cyc;
        push_exp(r + 15, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        sample();
        check("busy_timeout_cycle", 32'(busy), 32'd1);
        tick();
        sample();
        check("op_ready_after_err", 32'(op_ready), 32'd1);
        tick();

        // Result in the last permitted EXEC cycle is still accepted
        issue_op(3'd2, 3'd3, 3'd7, 1'b1);
        r = cyc;
        for (int i = 0; i < 15; i++) tick();
        alu_done   = 1'b1;
        alu_result = 8'h5F;
        push_exp(r + 16, 1'b1, 3'd7, 8'h5F, 1'b1, 1'b0);
        tick();
        alu_done = 1'b0;
        tick();

        // Compare-only op, stray alu_done during READ ignored, result after 3 cycles
        issue_op(3'd2, 3'd3, 3'd5, 1'b0);
        r = cyc;
        alu_done   = 1'b1;
        alu_result = 8'hFF;
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        alu_done   = 1'b1;
        alu_result = 8'hEE;
        push_exp(r + 4, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        tick();
        alu_done = 1'b0;
        sample();
        check("busy_after_cmp", 32'(busy), 32'd0);
        tick();

        // Async reset mid-EXEC discards the op
        issue_op(3'd2, 3'd3, 3'd6, 1'b1);
        tick();
        tick();
        #2;
        reset      = 1'b0;
        ld_valid   = 1'b1;
        ld_rd      = 3'd3;
        ld_data    = 8'hCC;
        alu_done   = 1'b1;
        alu_result = 8'h55;
        #1;
        check_all_zero("reset_mid_exec");
        tick();
        tick();
        reset    = 1'b1;
        ld_valid = 1'b0;
        alu_done = 1'b0;
        sample();
        check("op_ready_after_abort", 32'(op_ready), 32'd1);
        check("busy_after_abort", 32'(busy), 32'd0);
        tick();

        // Load to R2 during READ of R2: READ sees the old value
        issue_op(3'd2, 3'd3, 3'd5, 1'b1);
        r = cyc;
        ld_valid = 1'b1;
        ld_rd    = 3'd2;
        ld_data  = 8'h77;
        push_exp(r, 1'b1, 3'd2, 8'h77, 1'b0, 1'b0);
        tick();
        ld_valid   = 1'b0;
        alu_done   = 1'b1;
        alu_result = 8'h01;
        push_exp(r + 2, 1'b1, 3'd5, 8'h01, 1'b1, 1'b0);
        sample();
        check("alu_a_no_forward", 32'(alu_a), 32'h12);
        check("alu_b_r3_kept", 32'(alu_b), 32'h34);
        tick();
        alu_done = 1'b0;
        tick();

        issue_op(3'd2, 3'd2, 3'd4, 1'b0);
        r = cyc;
        tick();
        alu_done   = 1'b1;
        alu_result = 8'h00;
        push_exp(r + 1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        sample();
        check("alu_a_new_r2", 32'(alu_a), 32'h77);
        check("alu_b_new_r2", 32'(alu_b), 32'h77);
        tick();
        alu_done = 1'b0;
        tick();

        // Every expected event must have been seen
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
